// File: rtl/hilo_sched_pkg.sv
// ---------------------------------------------------------------------------
// hilo_sched_pkg : HI/LO op encodings and FSM state type shared with E-stage CU
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hilo_sched_pkg;

  localparam logic [3:0] HILO_NONE  = 4'd0;
  localparam logic [3:0] HILO_MULT  = 4'd1;
  localparam logic [3:0] HILO_MULTU = 4'd2;
  localparam logic [3:0] HILO_DIV   = 4'd3;
  localparam logic [3:0] HILO_DIVU  = 4'd4;
  localparam logic [3:0] HILO_MTHI  = 4'd5;
  localparam logic [3:0] HILO_MTLO  = 4'd6;
  localparam logic [3:0] HILO_MFHI  = 4'd7;
  localparam logic [3:0] HILO_MFLO  = 4'd8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } hilo_state_e;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == HILO_MULT) || (op == HILO_MULTU) ||
           (op == HILO_DIV)  || (op == HILO_DIVU);
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return (op == HILO_MULT) || (op == HILO_MULTU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hilo_arith.sv
// ---------------------------------------------------------------------------
// hilo_arith : combinational 64-bit mult/div result generator with div-by-zero flag
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hilo_arith
  import hilo_sched_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div0_o
);

  logic signed [63:0] w_smul;
  logic        [63:0] w_umul;
  logic               w_sdiv;
  logic               w_a_neg;
  logic               w_b_neg;
  logic        [31:0] w_a_mag;
  logic        [31:0] w_b_mag;
  logic        [31:0] w_b_safe;
  logic        [31:0] w_q_mag;
  logic        [31:0] w_r_mag;
  logic               w_b_zero;

  always_comb begin
    w_smul   = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    w_umul   = {32'd0, a_i} * {32'd0, b_i};
    w_sdiv   = (op_i == HILO_DIV);
    w_a_neg  = w_sdiv & a_i[31];
    w_b_neg  = w_sdiv & b_i[31];
    // Magnitude division; |0x80000000| fits unsigned, so MIN/-1 needs no special case.
    w_a_mag  = w_a_neg ? (~a_i + 32'd1) : a_i;
    w_b_mag  = w_b_neg ? (~b_i + 32'd1) : b_i;
    w_b_zero = (b_i == 32'd0);
    w_b_safe = w_b_zero ? 32'd1 : w_b_mag;
    w_q_mag  = w_a_mag / w_b_safe;
    w_r_mag  = w_a_mag % w_b_safe;
    hi_o     = 32'd0;
    lo_o     = 32'd0;
    div0_o   = 1'b0;
    case (op_i)
      HILO_MULT:  {hi_o, lo_o} = w_smul;
      HILO_MULTU: {hi_o, lo_o} = w_umul;
      HILO_DIV, HILO_DIVU: begin
        lo_o   = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
        hi_o   = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;
        div0_o = w_b_zero;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/hilo_sched.sv
// ---------------------------------------------------------------------------
// hilo_sched : multi-cycle mult/div scheduler owning HI/LO; optional HILO_CANCEL_EN
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hilo_sched
  import hilo_sched_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [3:0]  op_i,
  input  logic [31:0] d1_i,
  input  logic [31:0] d2_i,
  input  logic        cancel_i,
  output logic        busy_o,
  output logic        stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] out_o
);

  localparam logic [3:0] C_MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] C_DIV_CNT  = 4'(DIV_CYCLES);

  hilo_state_e state_q;
  logic [3:0]  cnt_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] pend_hi_q;
  logic [31:0] pend_lo_q;
  logic        pend_div0_q;

  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic        w_div0;
  logic        w_go;

  hilo_arith u_arith (
    .op_i   (op_i),
    .a_i    (d1_i),
    .b_i    (d2_i),
    .hi_o   (w_res_hi),
    .lo_o   (w_res_lo),
    .div0_o (w_div0)
  );

`ifdef HILO_CANCEL_EN
  assign w_go = start_i & ~cancel_i;
`else
  logic w_unused_cancel;
  assign w_unused_cancel = cancel_i;
  assign w_go            = start_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      pend_hi_q   <= 32'd0;
      pend_lo_q   <= 32'd0;
      pend_div0_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_go) begin
            if (is_muldiv(op_i)) begin
              pend_hi_q   <= w_res_hi;
              pend_lo_q   <= w_res_lo;
              pend_div0_q <= w_div0;
              cnt_q       <= is_mul(op_i) ? C_MULT_CNT : C_DIV_CNT;
              state_q     <= ST_RUN;
            end else if (op_i == HILO_MTHI) begin
              hi_q <= d1_i;
            end else if (op_i == HILO_MTLO) begin
              lo_q <= d1_i;
            end
          end
        end
        ST_RUN: begin
          // Any Start seen here is a hazard-unit bug and is dropped.
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= ST_IDLE;
            if (!pend_div0_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o  = (state_q == ST_RUN);
  assign stall_o = busy_o | (start_i & is_muldiv(op_i));
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

  always_comb begin
    out_o = 32'd0;
    if (op_i == HILO_MFHI)      out_o = hi_q;
    else if (op_i == HILO_MFLO) out_o = lo_q;
  end

endmodule

`default_nettype wire

// File: doc/hilo_sched.md
# hilo_sched

Multi-cycle multiply/divide scheduler for the E stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from the E-stage control decode and owns the HI/LO registers. It models the fixed multiply and divide latencies with a counter-driven FSM, and raises a stall request so the hazard unit can hold D-stage multiply/divide instructions. It also drives the MFHI/MFLO read path into the E-stage Y mux.

## Interface
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1–15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1–15)

Ports:
- Clk  in  1  clock; every state change happens on the rising edge
- Rst  in  1  asynchronous, active-high reset
- Start  in  1  E-stage instruction in Op is valid this cycle
- Op  in  4  operation code, using `HILO_*` encodings from const.v
- D1  in  32  forwarded rs value
- D2  in  32  forwarded rt value
- Cancel  in  1  exception flush of the current E-stage instruction
- Busy  out  1  an operation is in flight
- Stall  out  1  stall request to the hazard unit
- HI  out  32  HI register
- LO  out  32  LO register
- Out  out  32  value for MFHI/MFLO

## Operation
- FSM states:
  - IDLE.
  - RUN: a countdown counter `cnt` (4 bits) is active.
- IDLE, Start with Op ∈ {MULT, MULTU, DIV, DIVU}:
  - Latch the 64-bit result into `pend_hi`/`pend_lo`, computed from D1/D2 in the same cycle.
  - Set `cnt` = MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
- RUN: `cnt` decrements every edge. On the edge where `cnt` == 1, HI/LO ← pend_hi/pend_lo and the FSM returns to IDLE.
- MULT: signed 64-bit product, {HI, LO}.
- MULTU: unsigned 64-bit product, {HI, LO}.
- DIV/DIVU:
  - LO = quotient, HI = remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed): LO = 0x80000000, HI = 0.
  - Divide by zero: the busy period runs normally, and HI/LO keep their previous values at commit.
- MTHI/MTLO with Start in IDLE: HI (or LO) ← D1 on the edge. No busy period.
- Start in RUN: ignored entirely. The hazard unit must never let this happen; verification asserts it.
- Out = HI when Op == MFHI, LO when Op == MFLO, 0 otherwise. Purely combinational from the current registers. In RUN, Out shows the old HI/LO; the stall prevents that value from being consumed.
- Busy = (state == RUN).
- Stall = Busy | (Start & Op ∈ {MULT, MULTU, DIV, DIVU}).

## Timing
- Reset values: HI = 0, LO = 0, pend_hi = 0, pend_lo = 0, cnt = 0, state IDLE, Busy = 0. Out and Stall follow combinationally.
- Start sampled at edge T:
  - Busy is high from T through T+N (exactly N cycles).
  - The new HI/LO are visible after edge T+N.
  - Busy is low in the cycle after T+N.
- Back-to-back: a new Start can be accepted in the first cycle in which Busy = 0.
- Reset asserted mid-RUN: immediate abort; all registers take their reset values and no commit occurs.
- Write ordering: commit and MTHI/MTLO never coincide, because MT* is ignored in RUN.

## Configuration
- HILO_CANCEL_EN defined:
  - Cancel high in the Start cycle suppresses that Start. No latch, no RUN, no MTHI/MTLO write.
  - Stall still follows the formula above.
  - Cancel during RUN does not abort the in-flight operation; it belongs to an older, committed instruction.
- HILO_CANCEL_EN undefined: Cancel is ignored and every Start executes.

## Structure
- Shared const.v (shared package) holds the `HILO_MULT`, `HILO_MULTU`, `HILO_DIV`, `HILO_DIVU`, `HILO_MTHI`, `HILO_MTLO`, `HILO_MFHI`, `HILO_MFLO` and `HILO_NONE` encodings. The E-stage CU uses the same constants.
- One sub-module, `hilo_arith`: a combinational 64-bit result generator (signed/unsigned multiply, divide, div-by-zero flag). The FSM, counter and registers stay in `hilo_sched`.

## Test plan
- MULT D1 = 3, D2 = 0xFFFFFFFE → Busy for 5 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFFA; Out with MFLO = 0xFFFFFFFA.
- DIVU 7 / 2 → Busy for 10 cycles; LO = 3, HI = 1. DIV 0xFFFFFFF9 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- HI = 0x11, LO = 0x22, then DIV x / 0 → Busy for 10 cycles; HI = 0x11, LO = 0x22 unchanged.
- MTLO 0xABCD in IDLE → LO = 0xABCD after 1 edge, Busy stays 0. MTHI 0x55 issued during RUN → HI unchanged; the assertion fires.
- Rst pulse at cycle 3 of a MULT (asynchronous, mid-clock) → Busy = 0, HI = LO = 0 immediately; no commit follows.
- Cancel with MULT 4 × 4:
  - HILO_CANCEL_EN defined → Busy stays 0, LO unchanged.
  - HILO_CANCEL_EN undefined → LO = 16 after 5 cycles.
